// File: rtl/apb_pkg.sv
// Shared types and constants for the load/store-to-APB3 bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int         APB_ADDR_W      = 32;
  localparam int         APB_DATA_W      = 32;
  localparam int         APB_TIMEOUT_DEF = 16;
  // Any set bit under this mask marks a request that is not word aligned
  localparam logic [1:0] APB_ALIGN_MASK  = 2'b11;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_master.sv
// Single-beat valid/ready request to APB3 SETUP/ACCESS transfer, with a
// bounded wait on pready and a one-cycle response pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e        r_state;
  apb_state_e        w_state_next;
  apb_req_t          r_req;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_timeout_hit;
  logic              w_load;
  logic              w_rsp_fire;
  logic              w_rsp_err;
  logic              w_rsp_timeout;
  logic [DATA_W-1:0] w_rsp_rdata;

  assign req_ready     = (r_state == IDLE);
  assign w_accept      = req_valid && req_ready;
  assign w_misaligned  = |(req_addr[1:0] & APB_ALIGN_MASK);
  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_rsp_fire    = 1'b0;
    w_rsp_err     = 1'b0;
    w_rsp_timeout = 1'b0;
    w_rsp_rdata   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_rsp_fire = 1'b1;
            w_rsp_err  = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_state_next = SETUP;
          end
        end
      end
      SETUP: w_state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          w_state_next = IDLE;
          w_rsp_fire   = 1'b1;
          w_rsp_err    = pslverr;
          w_rsp_rdata  = (r_req.write || pslverr) ? '0 : prdata;
        end else if (w_timeout_hit) begin
          w_state_next  = IDLE;
          w_rsp_fire    = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_req         <= '0;
      r_wait_cnt    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_err     <= w_rsp_err;
        r_rsp_timeout <= w_rsp_timeout;
        r_rsp_rdata   <= w_rsp_rdata;
      end
      if (w_load) begin
        r_req.write <= req_write;
        r_req.addr  <= APB_ADDR_W'(req_addr);
        r_req.wdata <= APB_DATA_W'(req_wdata);
      end
      // Counts ACCESS cycles spent waiting; restarts with every new transfer
      if (w_load)
        r_wait_cnt <= '0;
      else if (r_state == ACCESS && !pready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign psel        = (r_state != IDLE);
  assign penable     = (r_state == ACCESS);
  assign pwrite      = r_req.write;
  assign paddr       = ADDR_W'(r_req.addr);
  assign pwdata      = DATA_W'(r_req.wdata);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Randomised bench for apb_master: a transaction-level model predicts
// latency, bus activity and response for each request.
module tb_apb_master;

  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic        psel0, penable0, pwrite0, pready0;
  logic [31:0] rsp_rdata0, paddr0, pwdata0;

  int     n_checks = 0;
  int     n_errors = 0;
  longint edge_cnt = 0;
  longint last_acc_edge = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_noto (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .rsp_timeout(rsp_timeout0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0),
    .pwdata(pwdata0), .prdata(prdata), .pready(pready0), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level prediction: outcome and cycle counts from the request alone
  task automatic model(input logic wr, input logic [31:0] addr, input int waits,
                       input logic slverr, input logic [31:0] rdv,
                       output int lat, output logic err, output logic tmo,
                       output logic [31:0] rdata, output int n_sel, output int n_en);
    if (addr % 4 != 0) begin
      lat = 1; err = 1'b1; tmo = 1'b0; rdata = 0; n_sel = 0; n_en = 0;
    end else if (TO != 0 && waits >= TO) begin
      lat = 2 + TO; err = 1'b1; tmo = 1'b1; rdata = 0; n_sel = TO + 1; n_en = TO;
    end else begin
      lat = 3 + waits; err = slverr; tmo = 1'b0;
      rdata = (wr || slverr) ? 32'h0 : rdv;
      n_sel = waits + 2; n_en = waits + 1;
    end
  endtask

  // Entered and left on a falling edge; plays the APB slave meanwhile
  task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic slverr, input logic [31:0] rdv);
    int          e_lat, e_sel, e_en, lat, t_acc, n_sel, n_en, n_acc;
    int          bad_bus, busy_ready, spurious;
    logic        e_err, e_tmo, acc_now, got;
    logic [31:0] e_rdata;
    model(wr, addr, waits, slverr, rdv, e_lat, e_err, e_tmo, e_rdata, e_sel, e_en);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    t_acc = -1; lat = -1; n_sel = 0; n_en = 0; n_acc = 0;
    bad_bus = 0; busy_ready = 0; spurious = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (penable) begin
        pready  = (n_acc >= waits);
        pslverr = pready ? slverr : 1'($urandom);
        prdata  = pready ? rdv : $urandom;
        n_acc++;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      acc_now = req_valid && req_ready;
      @(negedge sys_clk);
      if (acc_now) begin
        t_acc = c; req_valid = 1'b0; last_acc_edge = edge_cnt;
      end
      if (psel) begin
        n_sel++;
        if (req_ready) busy_ready++;
        if (paddr !== addr || pwrite !== wr || pwdata !== wdata) bad_bus++;
      end
      if (penable) n_en++;
      if (rsp_valid) begin
        if (t_acc < 0) spurious++;
        else begin got = 1'b1; lat = c + 1 - t_acc; end
      end
    end
    req_valid = 1'b0;
    check({tag, "/rsp_seen"}, got, 1'b1);
    if (got) begin
      check({tag, "/latency"}, lat, e_lat);
      check({tag, "/err"}, rsp_err, e_err);
      check({tag, "/timeout"}, rsp_timeout, e_tmo);
      check({tag, "/rdata"}, rsp_rdata, e_rdata);
    end
    check({tag, "/psel_cycles"}, n_sel, e_sel);
    check({tag, "/penable_cycles"}, n_en, e_en);
    check({tag, "/bus_unstable"}, bad_bus, 0);
    check({tag, "/ready_while_busy"}, busy_ready, 0);
    check({tag, "/spurious_rsp"}, spurious, 0);
  endtask

  initial begin
    logic        wr, slverr;
    logic [31:0] addr;
    int          waits, r, n, seen;
    longint      acc1;

    sys_rst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; pready0 = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge sys_clk);
    check("reset/psel", psel, 1'b0);
    check("reset/penable", penable, 1'b0);
    check("reset/pwrite", pwrite, 1'b0);
    check("reset/paddr", paddr, 32'h0);
    check("reset/pwdata", pwdata, 32'h0);
    check("reset/rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check("reset/rdata", rsp_rdata, 32'h0);
    check("reset/req_ready", req_ready, 1'b1);
    sys_rst_n = 1'b1;

    run_xfer("wr_deadbeef", 1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    run_xfer("rd_wait2", 1'b0, 32'h4000_0008, 32'h0, 2, 1'b0, 32'h1234_5678);
    run_xfer("rd_slverr", 1'b0, 32'h4000_000C, 32'h0, 0, 1'b1, 32'hCAFE_F00D);
    run_xfer("rd_wait15", 1'b0, 32'h4000_0010, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE);
    run_xfer("rd_timeout", 1'b0, 32'h4000_0014, 32'h0, TO, 1'b0, 32'h1111_2222);
    run_xfer("wr_tied_low", 1'b1, 32'h4000_0018, 32'h5555_AAAA, 1000, 1'b0, 32'h0);
    run_xfer("misaligned", 1'b1, 32'h4000_0006, 32'h7777_7777, 0, 1'b0, 32'h0);

    // Reset in the third ACCESS wait cycle drops the transfer
    pready = 1'b0;
    req_write = 1'b0; req_addr = 32'h4000_0020; req_valid = 1'b1;
    @(negedge sys_clk); req_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("midrst/in_access", {psel, penable}, 2'b11);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midrst/bus_idle", {psel, penable}, 2'b00);
    check("midrst/no_rsp", rsp_valid, 1'b0);
    sys_rst_n = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge sys_clk); if (rsp_valid || psel) seen++; end
    check("midrst/quiet_after", seen, 0);

    run_xfer("b2b_first", 1'b1, 32'h4000_0030, 32'h0102_0304, 0, 1'b0, 32'h0);
    acc1 = last_acc_edge;
    run_xfer("b2b_second", 1'b0, 32'h4000_0034, 32'h0, 0, 1'b0, 32'h8765_4321);
    check("b2b/spacing", 64'(last_acc_edge - acc1), 64'd3);

    for (int i = 0; i < 40; i++) begin
      r      = $urandom_range(0, 9);
      wr     = 1'($urandom);
      addr   = 32'h4000_0000 | ($urandom & 32'h0000_0FFC);
      if (r == 0) addr[1:0] = 2'($urandom_range(1, 3));
      waits  = (r == 1) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 4);
      slverr = ($urandom_range(0, 3) == 0);
      run_xfer($sformatf("rnd%0d", i), wr, addr, $urandom, waits, slverr, $urandom);
      if ($urandom_range(0, 2) == 0) @(negedge sys_clk);
    end

    // TIMEOUT=0 instance: a long pready-low stretch must never abort
    pslverr = 1'b0;
    req_write = 1'b0; req_addr = 32'h4000_0040; req_wdata = 32'h0;
    req_valid0 = 1'b1; pready0 = 1'b0;
    @(negedge sys_clk); req_valid0 = 1'b0;
    check("noto/setup", {psel0, penable0}, 2'b10);
    n = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sys_clk);
      if (psel0 && penable0) n++;
      if (rsp_valid0) seen++;
    end
    check("noto/wait_cycles", n, 100);
    check("noto/no_abort", seen, 0);
    check("noto/paddr", paddr0, 32'h4000_0040);
    check("noto/pwrite_pwdata", {pwrite0, pwdata0}, 33'h0);
    check("noto/ready_busy", req_ready0, 1'b0);
    pready0 = 1'b1; prdata = 32'hA5A5_0F0F;
    @(negedge sys_clk);
    pready0 = 1'b0;
    check("noto/rsp_valid", rsp_valid0, 1'b1);
    check("noto/err_timeout", {rsp_err0, rsp_timeout0}, 2'b00);
    check("noto/rdata", rsp_rdata0, 32'hA5A5_0F0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
